// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    // One prefetch slot: request address, returned word, and whether it has returned.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus: valid/ready requests, in-order responses.
interface fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch buffer. Entries are allocated in request order and filled in
// response order, so filled entries always form a contiguous run starting at the head.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    localparam int unsigned PW    = $clog2(QDEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         alloc,
    input  logic [31:0]  alloc_pc,
    input  logic         fill,
    input  logic [31:0]  fill_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         head_filled,
    output logic [CW-1:0] count,
    output logic [CW-1:0] unfilled
);

    fetch_entry_t  entries [QDEPTH];
    logic [PW-1:0] head_ptr_q, alloc_ptr_q, fill_ptr_q;
    logic [CW-1:0] count_q, unfilled_q;

    // Slot storage and pointer/occupancy bookkeeping; clear drops everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                entries[i] <= '0;
            end
            head_ptr_q  <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            count_q     <= '0;
            unfilled_q  <= '0;
        end else if (clear) begin
            head_ptr_q  <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            count_q     <= '0;
            unfilled_q  <= '0;
        end else begin
            if (alloc) begin
                entries[alloc_ptr_q] <= '{pc: alloc_pc, data: NOP_INSTR, filled: 1'b0};
                alloc_ptr_q          <= alloc_ptr_q + PW'(1);
            end
            if (fill) begin
                entries[fill_ptr_q].data   <= fill_data;
                entries[fill_ptr_q].filled <= 1'b1;
                fill_ptr_q                 <= fill_ptr_q + PW'(1);
            end
            if (pop) begin
                head_ptr_q <= head_ptr_q + PW'(1);
            end
            count_q    <= count_q + CW'(alloc) - CW'(pop);
            unfilled_q <= unfilled_q + CW'(alloc) - CW'(fill);
        end
    end

    // Head view; stale filled bits in freed slots are masked by the occupancy.
    always_comb begin
        head        = entries[head_ptr_q];
        head_filled = (count_q != '0) && entries[head_ptr_q].filled;
        count       = count_q;
        unfilled    = unfilled_q;
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC, request gating, wrong-path response dropping and IF output mux.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stallF,
    input  logic                 PCSrcE,
    input  logic [31:0]          PCTargetE,
    fetch_stage_if.master        imem,
    output logic [31:0]          instrF,
    output logic [31:0]          PCF,
    output logic [31:0]          PCPlus4F,
    output logic                 validF,
    output logic                 fetch_wait
);

    localparam int unsigned CW = $clog2(QDEPTH) + 1;
    // In-flight wrong-path responses can reach 2*QDEPTH (old drops plus a refilled queue).
    localparam int unsigned DW = $clog2(2 * QDEPTH) + 1;

    logic [31:0]   req_pc_q, req_pc_d;
    logic [DW-1:0] drop_q, drop_d;
    fetch_entry_t  head;
    logic          head_filled;
    logic [CW-1:0] count, unfilled;
    logic          accept, fill, pop;

    // Request gating uses registered occupancy, so a same-cycle pop never frees a slot early.
    always_comb begin
        imem.imem_req  = rst_n && (count < CW'(QDEPTH)) && !PCSrcE;
        imem.imem_addr = req_pc_q;
        accept         = imem.imem_req && imem.imem_ready;
        fill           = imem.imem_rvalid && (drop_q == '0) && !PCSrcE;
        pop            = head_filled && !stallF && !PCSrcE;
    end

    // Next request PC and drop count; a redirect turns every unfilled slot into a pending drop.
    always_comb begin
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        if (PCSrcE) begin
            req_pc_d = PCTargetE;
            // A same-cycle response retires one in-flight request whichever pool it came from.
            drop_d   = drop_q + DW'(unfilled) - DW'(imem.imem_rvalid);
        end else begin
            if (accept) begin
                req_pc_d = req_pc_q + 32'd4;
            end
            if (imem.imem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - DW'(1);
            end
        end
    end

    // PC and drop-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc_q <= RESET_PC;
            drop_q   <= '0;
        end else begin
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (PCSrcE),
        .alloc       (accept),
        .alloc_pc    (req_pc_q),
        .fill        (fill),
        .fill_data   (imem.imem_rdata),
        .pop         (pop),
        .head        (head),
        .head_filled (head_filled),
        .count       (count),
        .unfilled    (unfilled)
    );

    // Head-driven IF outputs; an empty queue reports the PC about to be requested.
    always_comb begin
        validF     = head_filled;
        fetch_wait = !head_filled;
        instrF     = head_filled ? head.data : NOP_INSTR;
        PCF        = (count != '0) ? head.pc : req_pc_q;
        PCPlus4F   = PCF + 32'd4;
    end

    // A response with nothing to fill and nothing to drop means the memory broke protocol.
    assert property (@(posedge clk) disable iff (!rst_n)
        imem.imem_rvalid |-> ((drop_q != '0) || (unfilled != '0)));

endmodule
